// File: rtl/ip_mem_arbiter.sv
// ip_mem_arbiter: shares the single data-memory port between the CPU EX-stage
// access and the IP block's read/write requests. Round-robin arbitration,
// request latching into the memory port, registered completion pulses, and a
// pipeline stall for the ID/EX hold input.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> a grant aborts after TIMEOUT cycles without mem_ready, the
//                done pulse is still issued with read data forced to 0, and
//                timeout_err sets and stays set until reset.
//   undefined -> a grant waits indefinitely, timeout_err is tied to 0.
module ip_mem_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ip_read,
    input  logic              ip_write,
    input  logic [ADDR_W-1:0] ip_addr,
    input  logic [DATA_W-1:0] ip_wdata,
    output logic [DATA_W-1:0] ip_rdata,
    output logic              ip_ack,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              last_grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_IP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic cpu_done;
    logic ip_req;
    logic cpu_active;
    logic ip_active;
    logic start_cpu;
    logic start_ip;
    logic finish;
    logic abort;

    // A requester whose done pulse is high this cycle is still holding its
    // request line, so it is masked to avoid an immediate re-grant.
    assign ip_req     = ip_read | ip_write;
    assign cpu_active = cpu_req & ~cpu_done;
    assign ip_active  = ip_req & ~ip_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;

    // Abort on the last allowed waiting cycle; a mem_ready in that same cycle
    // still wins and completes the access normally.
    assign abort = (state != IDLE) && !mem_ready &&
                   (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Wait counter held at zero while idle, counts unanswered grant cycles; sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (!mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: round-robin arbitration in IDLE, completion or abort in a grant
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_active && ip_active) begin
                    state_next = last_grant ? GNT_CPU : GNT_IP;
                end else if (cpu_active) begin
                    state_next = GNT_CPU;
                end else if (ip_active) begin
                    state_next = GNT_IP;
                end
            end
            GNT_CPU, GNT_IP: begin
                if (mem_ready || abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: grant/finish strobes and the combinational pipeline stall
    always_comb begin
        start_cpu = (state == IDLE) && (state_next == GNT_CPU);
        start_ip  = (state == IDLE) && (state_next == GNT_IP);
        finish    = (state != IDLE) && (state_next == IDLE);
        cpu_stall = rst & cpu_req & ~cpu_done;
    end

    // Memory port latching, read-data capture and one-cycle done pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            ip_rdata   <= '0;
            cpu_done   <= 1'b0;
            ip_ack     <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            ip_ack   <= 1'b0;
            if (start_cpu) begin
                mem_en     <= 1'b1;
                mem_rw     <= cpu_rw;
                mem_addr   <= cpu_addr;
                mem_wdata  <= cpu_wdata;
                last_grant <= 1'b0;
            end else if (start_ip) begin
                mem_en     <= 1'b1;
                mem_rw     <= ip_write;
                mem_addr   <= ip_addr;
                mem_wdata  <= ip_wdata;
                last_grant <= 1'b1;
            end else if (finish) begin
                mem_en <= 1'b0;
                if (state == GNT_CPU) begin
                    cpu_done <= 1'b1;
                    if (!mem_rw) begin
                        cpu_rdata <= abort ? '0 : mem_rdata;
                    end
                end else begin
                    ip_ack <= 1'b1;
                    if (!mem_rw) begin
                        ip_rdata <= abort ? '0 : mem_rdata;
                    end
                end
            end
        end
    end

endmodule
